// File: rtl/hazard_ctrl_pkg.sv
// Shared types and default 5-stage masks for the pipeline hazard controller.
// Bit 0 of every mask is IF/PC, bit 1 is IF/ID, and so on down the pipe.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HC_IDLE = 2'd0,
        HC_WAIT = 2'd1,
        HC_DONE = 2'd2
    } div_state_e;

    localparam int         DEF_STAGES     = 5;
    localparam logic [4:0] DEF_LU_STALL   = 5'b00011;
    localparam logic [4:0] DEF_LU_FLUSH   = 5'b00100;
    localparam logic [4:0] DEF_BR_FLUSH   = 5'b00010;
    localparam logic [4:0] DEF_DIV_STALL  = 5'b00111;
    localparam logic [4:0] DEF_DIV_FLUSH  = 5'b01000;
    localparam logic [4:0] DEF_MW_STALL   = 5'b01111;
    localparam logic [4:0] DEF_MW_FLUSH   = 5'b10000;
    localparam logic [4:0] DEF_TRAP_FLUSH = 5'b01111;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard requests from the datapath and the stall/flush/divider controls back to it.
// The controller takes the slave view; the datapath (or a bench) takes the master view.
interface hazard_ctrl_if #(
    parameter int STAGES = 5
);
    logic              mem_trap_i;
    logic              mem_wait_i;
    logic              ex_div_i;
    logic              div_done_i;
    logic              id_branch_flush_i;
    logic              id_load_use_i;
    logic [STAGES-1:0] stall_o;
    logic [STAGES-1:0] flush_o;
    logic              div_start_o;
    logic              div_kill_o;
    logic              wdog_o;

    modport master (
        output mem_trap_i, mem_wait_i, ex_div_i, div_done_i,
               id_branch_flush_i, id_load_use_i,
        input  stall_o, flush_o, div_start_o, div_kill_o, wdog_o
    );

    modport slave (
        input  mem_trap_i, mem_wait_i, ex_div_i, div_done_i,
               id_branch_flush_i, id_load_use_i,
        output stall_o, flush_o, div_start_o, div_kill_o, wdog_o
    );
endinterface

// File: rtl/hazard_ctrl_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles, saturating at all-ones,
// and flags expiry once the counter is saturated.
module stall_wdog #(
    parameter int W = 10
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic stall_any,
    output logic expired
);
    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else if (!stall_any) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == '1);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush arbitration across trap,
// memory wait, divider, branch and load-use, plus the divider handshake FSM.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int                STAGES     = DEF_STAGES,
    parameter logic [STAGES-1:0] LU_STALL   = DEF_LU_STALL,
    parameter logic [STAGES-1:0] LU_FLUSH   = DEF_LU_FLUSH,
    parameter logic [STAGES-1:0] BR_FLUSH   = DEF_BR_FLUSH,
    parameter logic [STAGES-1:0] DIV_STALL  = DEF_DIV_STALL,
    parameter logic [STAGES-1:0] DIV_FLUSH  = DEF_DIV_FLUSH,
    parameter logic [STAGES-1:0] MW_STALL   = DEF_MW_STALL,
    parameter logic [STAGES-1:0] MW_FLUSH   = DEF_MW_FLUSH,
    parameter logic [STAGES-1:0] TRAP_FLUSH = DEF_TRAP_FLUSH,
    parameter int                EX_ADV_BIT = 3,
    parameter int                WDOG_W     = 10
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    hazard_ctrl_if.slave  hc
);
    div_state_e        state;
    div_state_e        state_nx;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic              div_start;
    logic              div_kill;
    logic              div_busy;
    logic              wdog;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= HC_IDLE;
        else          state <= state_nx;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        stall     = '0;
        flush     = '0;
        div_start = 1'b0;
        div_kill  = 1'b0;
        div_busy  = 1'b0;
        state_nx  = state;

        if (!rst_n_i) begin
            // Hold every pipeline register flushed while reset is asserted.
            flush    = '1;
            state_nx = HC_IDLE;
        end else begin
            div_start = (state == HC_IDLE) && hc.ex_div_i && !hc.mem_trap_i;
            div_busy  = div_start || (state == HC_WAIT);

            if (hc.mem_trap_i) begin
                flush    = TRAP_FLUSH;
                div_kill = (state == HC_WAIT);
            end else if (hc.mem_wait_i) begin
                stall = MW_STALL;
                flush = MW_FLUSH;
            end else if (div_busy) begin
                stall = DIV_STALL;
                flush = DIV_FLUSH;
            end else if (hc.id_branch_flush_i) begin
                // The load-use stall survives a redirect, but its bubble is
                // superseded by the branch flush.
                flush = BR_FLUSH;
                if (hc.id_load_use_i) stall = LU_STALL;
            end else if (hc.id_load_use_i) begin
                stall = LU_STALL;
                flush = LU_FLUSH;
            end

            if (hc.mem_trap_i) begin
                state_nx = HC_IDLE;
            end else begin
                unique case (state)
                    HC_IDLE: if (hc.ex_div_i)          state_nx = HC_WAIT;
                    HC_WAIT: if (hc.div_done_i)        state_nx = HC_DONE;
                    // Leave DONE only once the EX instruction actually advances.
                    HC_DONE: if (!stall[EX_ADV_BIT])   state_nx = HC_IDLE;
                    default:                           state_nx = HC_IDLE;
                endcase
            end
        end
    end

    stall_wdog #(
        .W (WDOG_W)
    ) u_stall_wdog (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .stall_any (|stall),
        .expired   (wdog)
    );

    assign hc.stall_o     = stall;
    assign hc.flush_o     = flush;
    assign hc.div_start_o = div_start;
    assign hc.div_kill_o  = div_kill;
    assign hc.wdog_o      = wdog;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a 3-bit watchdog so expiry is reachable
// in a handful of cycles.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam bit [5:0] V_NONE = 6'b000000;
    localparam bit [5:0] V_LU   = 6'b000001;
    localparam bit [5:0] V_BR   = 6'b000010;
    localparam bit [5:0] V_DONE = 6'b000100;
    localparam bit [5:0] V_DIV  = 6'b001000;
    localparam bit [5:0] V_MW   = 6'b010000;
    localparam bit [5:0] V_TRAP = 6'b100000;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    hazard_ctrl_if #(.STAGES(5)) hc_bus ();

    hazard_ctrl #(
        .WDOG_W (3)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .hc      (hc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit [5:0] v);
        {hc_bus.mem_trap_i, hc_bus.mem_wait_i, hc_bus.ex_div_i,
         hc_bus.div_done_i, hc_bus.id_branch_flush_i, hc_bus.id_load_use_i} = v;
    endtask

    // Apply a vector mid-cycle and let the combinational outputs settle.
    task automatic step(input bit [5:0] v);
        @(negedge clk);
        drive(v);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] st, input logic [4:0] fl);
        check({tag, ".stall"}, 32'(hc_bus.stall_o), 32'(st));
        check({tag, ".flush"}, 32'(hc_bus.flush_o), 32'(fl));
    endtask

    task automatic chk_state(input string tag, input div_state_e s);
        check({tag, ".state"}, 32'(dut.state), 32'(s));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(V_DIV);
        #3;
        chk_out("rst", 5'b00000, 5'b11111);
        check("rst.start", 32'(hc_bus.div_start_o), 32'd0);
        check("rst.kill",  32'(hc_bus.div_kill_o),  32'd0);
        check("rst.wdog",  32'(hc_bus.wdog_o),      32'd0);
        chk_state("rst", HC_IDLE);

        @(negedge clk);
        rst_n = 1'b1;
        drive(V_NONE);
        #1;
        chk_out("idle", 5'b00000, 5'b00000);

        // Load-use / branch arbitration
        step(V_LU);        chk_out("lu",     5'b00011, 5'b00100);
        step(V_NONE);      chk_out("lu_off", 5'b00000, 5'b00000);
        step(V_BR | V_LU); chk_out("br_lu",  5'b00011, 5'b00010);
        step(V_BR);        chk_out("br",     5'b00000, 5'b00010);
        step(V_MW | V_LU); chk_out("mw_lu",  5'b01111, 5'b10000);

        // Divide with done four cycles after start; branch in WAIT is ignored
        step(V_DIV);
        chk_out("div0", 5'b00111, 5'b01000);
        check("div0.start", 32'(hc_bus.div_start_o), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            step(V_DIV | ((c == 2) ? V_BR : V_NONE));
            chk_out("div_wait", 5'b00111, 5'b01000);
            check("div_wait.start", 32'(hc_bus.div_start_o), 32'd0);
            chk_state("div_wait", HC_WAIT);
        end
        step(V_DIV | V_DONE);
        chk_out("div4", 5'b00111, 5'b01000);
        chk_state("div4", HC_WAIT);
        step(V_DIV);
        chk_out("div5", 5'b00000, 5'b00000);
        check("div5.start", 32'(hc_bus.div_start_o), 32'd0);
        chk_state("div5", HC_DONE);
        step(V_NONE);
        chk_state("div6", HC_IDLE);
        chk_out("div6", 5'b00000, 5'b00000);

        // Trap while WAIT kills the divide; later done is ignored
        step(V_DIV);
        check("tw0.start", 32'(hc_bus.div_start_o), 32'd1);
        step(V_DIV | V_TRAP);
        chk_out("tw1", 5'b00000, 5'b01111);
        check("tw1.kill",  32'(hc_bus.div_kill_o),  32'd1);
        check("tw1.start", 32'(hc_bus.div_start_o), 32'd0);
        step(V_DONE);
        chk_state("tw2", HC_IDLE);
        check("tw2.kill", 32'(hc_bus.div_kill_o), 32'd0);
        chk_out("tw2", 5'b00000, 5'b00000);
        step(V_NONE);
        chk_state("tw3", HC_IDLE);

        // Trap coincident with done: trap wins
        step(V_DIV);
        step(V_DIV | V_TRAP | V_DONE);
        check("td.kill", 32'(hc_bus.div_kill_o), 32'd1);
        chk_out("td", 5'b00000, 5'b01111);
        step(V_NONE);
        chk_state("td_next", HC_IDLE);

        // Trap in IDLE suppresses the start and raises no kill
        step(V_DIV | V_TRAP);
        check("ti.start", 32'(hc_bus.div_start_o), 32'd0);
        check("ti.kill",  32'(hc_bus.div_kill_o),  32'd0);
        step(V_NONE);
        chk_state("ti_next", HC_IDLE);

        // Minimum 2-cycle divide, then mem_wait holds the FSM in DONE
        step(V_DIV);
        chk_out("md0", 5'b00111, 5'b01000);
        step(V_DIV | V_DONE);
        chk_out("md1", 5'b00111, 5'b01000);
        step(V_DIV | V_MW);
        chk_state("md_mw1", HC_DONE);
        chk_out("md_mw1", 5'b01111, 5'b10000);
        step(V_DIV | V_MW);
        chk_state("md_mw2", HC_DONE);
        step(V_DIV);
        chk_state("md_rel", HC_DONE);
        chk_out("md_rel", 5'b00000, 5'b00000);
        step(V_NONE);
        chk_state("md_idle", HC_IDLE);

        // Watchdog: expires after seven stalled cycles, saturates, then clears
        for (int i = 1; i <= 9; i++) begin
            step(V_MW);
            check($sformatf("wdog%0d", i), 32'(hc_bus.wdog_o), 32'(i >= 8));
        end
        step(V_NONE);
        check("wdog_hold", 32'(hc_bus.wdog_o), 32'd1);
        step(V_NONE);
        check("wdog_clr", 32'(hc_bus.wdog_o), 32'd0);

        // Reset mid-divide with the watchdog expired
        step(V_DIV);
        for (int i = 1; i <= 8; i++) step(V_DIV | V_MW);
        check("pre_rst.wdog", 32'(hc_bus.wdog_o), 32'd1);
        chk_state("pre_rst", HC_WAIT);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 5'b00000, 5'b11111);
        check("mid_rst.start", 32'(hc_bus.div_start_o), 32'd0);
        check("mid_rst.kill",  32'(hc_bus.div_kill_o),  32'd0);
        check("mid_rst.wdog",  32'(hc_bus.wdog_o),      32'd0);
        chk_state("mid_rst", HC_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        drive(V_NONE);
        #1;
        chk_out("post_rst", 5'b00000, 5'b00000);
        chk_state("post_rst", HC_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
